chnl_smpl_pack: RTL and testbench

Parametrised multi-channel comparator sampler for the capture path. It synchronises NCH high/low comparator pairs into `clk` and samples them on an internal decimated strobe. It packs SPW consecutive samples per channel into one word and hands each word to the capture RAM writer over a valid/ready handshake. A sticky flag records words dropped because of backpressure.

---
 rtl/chnl_smpl_pkg.sv | 20 ++
 rtl/chnl_sync.sv | 24 ++
 rtl/chnl_smpl_pack.sv | 139 +++++++++++++
 tb/tb_chnl_smpl_pack.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chnl_smpl_pkg.sv
// Shared constants and types for the multi-channel comparator sampler.
// Optional trigger feature in chnl_smpl_pack is enabled by CHNL_SMPL_TRIG_EN.
package chnl_smpl_pkg;

    localparam int unsigned NCH_DEF      = 5;
    localparam int unsigned SPW_DEF      = 4;
    localparam int unsigned DECW_DEF     = 8;
    localparam int unsigned SYNC_STG_DEF = 2;

    typedef struct packed {
        logic h;
        logic l;
    } smpl_pair_t;

    // Bits occupied by one channel inside a packed output word.
    function automatic int unsigned fld_w(input int unsigned spw);
        return 2 * spw;
    endfunction

endpackage

// File: rtl/chnl_sync.sv
// Vectorised multi-flop synchroniser; every bit is an independent SYNC_STG-deep chain.
module chnl_sync #(
    parameter int unsigned W        = 1,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [SYNC_STG-1:0][W-1:0] stg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg <= '0;
        end else begin
            stg <= {stg[SYNC_STG-2:0], d};
        end
    end

    assign q = stg[SYNC_STG-1];

endmodule

// File: rtl/chnl_smpl_pack.sv
// Comparator-pair sampler: synchronise, decimate, pack SPW samples/channel, valid/ready out.
// Define CHNL_SMPL_TRIG_EN to add the per-channel rising-edge trigger output trig_rise.
module chnl_smpl_pack
    import chnl_smpl_pkg::*;
#(
    parameter int unsigned NCH      = NCH_DEF,
    parameter int unsigned SPW      = SPW_DEF,   // must be >= 2
    parameter int unsigned DECW     = DECW_DEF,
    parameter int unsigned SYNC_STG = SYNC_STG_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arm,
    input  logic [DECW-1:0]               decim,
    input  logic [NCH-1:0]                CH_H,
    input  logic [NCH-1:0]                CH_L,
    output logic [NCH-1:0]                CH_Hff,
    output logic [NCH-1:0]                CH_Lff,
    output logic [NCH*fld_w(SPW)-1:0]     smpl_word,
    output logic                          smpl_vld,
    input  logic                          smpl_rdy,
    output logic                          ovfl,
    input  logic                          clr_ovfl
`ifdef CHNL_SMPL_TRIG_EN
    ,
    output logic [NCH-1:0]                trig_rise
`endif
);

    localparam int unsigned FW  = fld_w(SPW);
    localparam int unsigned WW  = NCH * FW;
    localparam int unsigned AW  = FW - 2;
    localparam int unsigned PCW = (SPW > 1) ? $clog2(SPW) : 1;

    logic [DECW-1:0]  cnt;
    logic [PCW-1:0]   pcnt;
    logic [NCH*AW-1:0] acc;

    logic             strobe_c;
    logic             word_done_c;
    logic             accept_c;
    logic             load_c;
    logic             drop_c;
    smpl_pair_t [NCH-1:0] pair_c;
    logic [WW-1:0]    acc_nxt_c;
    logic [NCH*AW-1:0] acc_shift_c;

    chnl_sync #(.W(NCH), .SYNC_STG(SYNC_STG)) u_sync_h (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (CH_H),
        .q     (CH_Hff)
    );

    chnl_sync #(.W(NCH), .SYNC_STG(SYNC_STG)) u_sync_l (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (CH_L),
        .q     (CH_Lff)
    );

    assign strobe_c    = arm && (cnt >= decim);
    assign word_done_c = strobe_c && (pcnt == PCW'(SPW - 1));
    assign accept_c    = smpl_vld && smpl_rdy;
    assign load_c      = word_done_c && (!smpl_vld || smpl_rdy);
    assign drop_c      = word_done_c && smpl_vld && !smpl_rdy;

    // Newest sample enters each channel field at the MSBs; the oldest leaves at the LSBs.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign pair_c[c] = smpl_pair_t'({CH_Hff[c], CH_Lff[c]});
        assign acc_nxt_c[c*FW +: FW] = {pair_c[c], acc[c*AW +: AW]};
    end

    // Accumulator keeps only the SPW-1 most recent samples; the word is completed combinationally.
    always_comb begin
        acc_shift_c = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            acc_shift_c[c*AW +: AW] = acc_nxt_c[c*FW + 2 +: AW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            pcnt      <= '0;
            acc       <= '0;
            smpl_word <= '0;
            smpl_vld  <= 1'b0;
            ovfl      <= 1'b0;
        end else begin
            if (!arm || strobe_c) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DECW'(1);
            end

            if (!arm) begin
                pcnt <= '0;
                acc  <= '0;
            end else if (strobe_c) begin
                pcnt <= word_done_c ? '0 : pcnt + PCW'(1);
                acc  <= acc_shift_c;
            end

            if (load_c) begin
                smpl_word <= acc_nxt_c;
                smpl_vld  <= 1'b1;
            end else if (accept_c) begin
                smpl_vld  <= 1'b0;
            end

            // A drop in the same cycle as a clear leaves the flag set.
            if (drop_c) begin
                ovfl <= 1'b1;
            end else if (clr_ovfl) begin
                ovfl <= 1'b0;
            end
        end
    end

`ifdef CHNL_SMPL_TRIG_EN
    logic [NCH-1:0] prev_h;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_h    <= '0;
            trig_rise <= '0;
        end else begin
            trig_rise <= strobe_c ? (CH_Hff & ~prev_h) : '0;
            if (!arm) begin
                prev_h <= '0;
            end else if (strobe_c) begin
                prev_h <= CH_Hff;
            end
        end
    end
`endif

endmodule

// File: tb/tb_chnl_smpl_pack.sv
// Randomised bench for chnl_smpl_pack against a sample-list reference model.
// Exercises the trigger output when CHNL_SMPL_TRIG_EN is defined.
module tb_chnl_smpl_pack;
    import chnl_smpl_pkg::*;

    localparam int unsigned NCH  = NCH_DEF;
    localparam int unsigned SPW  = SPW_DEF;
    localparam int unsigned DECW = DECW_DEF;
    localparam int unsigned SS   = SYNC_STG_DEF;
    localparam int unsigned FW   = 2 * SPW;
    localparam int unsigned WW   = NCH * FW;

    logic              clk;
    logic              rst_n;
    logic              arm;
    logic [DECW-1:0]   decim;
    logic [NCH-1:0]    CH_H;
    logic [NCH-1:0]    CH_L;
    logic [NCH-1:0]    CH_Hff;
    logic [NCH-1:0]    CH_Lff;
    logic [WW-1:0]     smpl_word;
    logic              smpl_vld;
    logic              smpl_rdy;
    logic              ovfl;
    logic              clr_ovfl;
`ifdef CHNL_SMPL_TRIG_EN
    logic [NCH-1:0]    trig_rise;
`endif

    chnl_smpl_pack #(.NCH(NCH), .SPW(SPW), .DECW(DECW), .SYNC_STG(SS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .decim     (decim),
        .CH_H      (CH_H),
        .CH_L      (CH_L),
        .CH_Hff    (CH_Hff),
        .CH_Lff    (CH_Lff),
        .smpl_word (smpl_word),
        .smpl_vld  (smpl_vld),
        .smpl_rdy  (smpl_rdy),
        .ovfl      (ovfl),
        .clr_ovfl  (clr_ovfl)
`ifdef CHNL_SMPL_TRIG_EN
        ,
        .trig_rise (trig_rise)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: pipeline of driven inputs, list of captured samples, output state.
    logic [NCH-1:0]   ph_q[$];
    logic [NCH-1:0]   pl_q[$];
    logic [2*NCH-1:0] smp_q[$];
    int               m_since;
    logic             m_vld;
    logic             m_ovfl;
    logic [WW-1:0]    m_word;
`ifdef CHNL_SMPL_TRIG_EN
    logic [NCH-1:0]   m_prev;
    logic [NCH-1:0]   m_trig;
`endif

    task automatic model_reset();
        ph_q.delete();
        pl_q.delete();
        for (int i = 0; i < int'(SS) - 1; i++) begin
            ph_q.push_back('0);
            pl_q.push_back('0);
        end
        ph_q.push_back(CH_H);
        pl_q.push_back(CH_L);
        smp_q.delete();
        m_since = 0;
        m_vld   = 1'b0;
        m_ovfl  = 1'b0;
        m_word  = '0;
`ifdef CHNL_SMPL_TRIG_EN
        m_prev  = '0;
        m_trig  = '0;
`endif
    endtask

    // One clock: check outputs at the falling edge, drive new inputs, advance the model.
    task automatic step(input logic a, input logic [DECW-1:0] d, input logic r, input logic c,
                        input logic [NCH-1:0] h, input logic [NCH-1:0] l);
        logic [NCH-1:0]   sh;
        logic [NCH-1:0]   sl;
        logic [2*NCH-1:0] s;
        logic [WW-1:0]    w;
        logic             strobe;
        logic             nv;
        logic             drop;
        @(negedge clk);
        cyc++;
        sh = ph_q[0];
        sl = pl_q[0];
        chk("ch_hff", 64'(CH_Hff), 64'(sh));
        chk("ch_lff", 64'(CH_Lff), 64'(sl));
        chk("vld", 64'(smpl_vld), 64'(m_vld));
        chk("word", 64'(smpl_word), 64'(m_word));
        chk("ovfl", 64'(ovfl), 64'(m_ovfl));
`ifdef CHNL_SMPL_TRIG_EN
        chk("trig", 64'(trig_rise), 64'(m_trig));
`endif
        arm      = a;
        decim    = d;
        smpl_rdy = r;
        clr_ovfl = c;
        CH_H     = h;
        CH_L     = l;

        strobe = a && (m_since >= int'(d));
        nv     = m_vld && !r ? 1'b1 : 1'b0;
        drop   = 1'b0;
        if (!a) begin
            smp_q.delete();
            m_since = 0;
        end else if (strobe) begin
            m_since = 0;
            for (int ch = 0; ch < int'(NCH); ch++) s[2*ch +: 2] = {sh[ch], sl[ch]};
            smp_q.push_back(s);
            if (smp_q.size() == SPW) begin
                w = '0;
                for (int k = 0; k < int'(SPW); k++)
                    for (int ch = 0; ch < int'(NCH); ch++)
                        w[ch*FW + 2*k +: 2] = smp_q[k][2*ch +: 2];
                smp_q.delete();
                if (!m_vld || r) begin
                    nv     = 1'b1;
                    m_word = w;
                end else begin
                    drop = 1'b1;
                end
            end
        end else begin
            m_since++;
        end
        m_vld = nv;
        if (drop) m_ovfl = 1'b1;
        else if (c) m_ovfl = 1'b0;
`ifdef CHNL_SMPL_TRIG_EN
        m_trig = strobe ? (sh & ~m_prev) : '0;
        if (!a) m_prev = '0;
        else if (strobe) m_prev = sh;
`endif
        void'(ph_q.pop_front());
        void'(pl_q.pop_front());
        ph_q.push_back(h);
        pl_q.push_back(l);
    endtask

    function automatic logic [NCH-1:0] rnd();
        return NCH'($urandom);
    endfunction

    initial begin
        logic [3:0]      pat;
        logic [NCH-1:0]  h;
        logic [NCH-1:0]  l;
        logic [WW-1:0]   held;
        logic [DECW-1:0] dcur;
        logic            acur;
        int              first;
        int              gap;
        int              pulses;

        rst_n    = 1'b0;
        arm      = 1'b0;
        decim    = '0;
        smpl_rdy = 1'b0;
        clr_ovfl = 1'b0;
        CH_H     = '0;
        CH_L     = '0;
        model_reset();
        #3;
        chk("rst_vld", 64'(smpl_vld), 64'd0);
        chk("rst_word", 64'(smpl_word), 64'd0);
        chk("rst_ovfl", 64'(ovfl), 64'd0);
        chk("rst_hff", 64'(CH_Hff), 64'd0);
        #9 rst_n = 1'b1;

        // Basic pack: CH_H[0] = 1,0,1,1 captured by four consecutive strobes.
        pat = 4'b1101;
        for (int i = 0; i <= int'(SS) + 3; i++) begin
            h = rnd();
            l = rnd();
            h[0] = (i < 4) ? pat[i] : 1'b0;
            l[0] = 1'b0;
            step(i >= int'(SS), '0, 1'b1, 1'b0, h, l);
        end
        step(1'b1, '0, 1'b1, 1'b0, rnd(), rnd());
        chk("pack_ch0", 64'(smpl_word[7:0]), 64'h0A2);
        chk("pack_vld", 64'(smpl_vld), 64'd1);
        for (int i = 0; i < 40; i++) step(1'b1, '0, 1'b1, 1'b0, rnd(), rnd());
        chk("rdy_hi_no_ovfl", 64'(ovfl), 64'd0);

        // Decimation 3: measure the spacing of word deliveries.
        first = -1;
        gap   = -1;
        for (int i = 0; i < 80 && gap < 0; i++) begin
            step(1'b1, DECW'(3), 1'b1, 1'b0, rnd(), rnd());
            if (smpl_vld) begin
                if (first < 0) first = cyc;
                else gap = cyc - first;
            end
        end
        chk("decim_gap", 64'(gap), 64'd16);
        for (int i = 0; i < 2; i++) step(1'b1, DECW'(3), 1'b1, 1'b0, rnd(), rnd());
        for (int i = 0; i < 6; i++) step(1'b1, DECW'(1), 1'b1, 1'b0, rnd(), rnd());

        // Backpressure over two word periods, then drain and clear.
        for (int i = 0; i < 10; i++) step(1'b1, DECW'(1), 1'b0, 1'b0, rnd(), rnd());
        held = smpl_word;
        for (int i = 0; i < 14; i++) step(1'b1, DECW'(1), 1'b0, 1'b0, rnd(), rnd());
        chk("bp_ovfl", 64'(ovfl), 64'd1);
        chk("bp_vld", 64'(smpl_vld), 64'd1);
        chk("bp_hold", 64'(smpl_word), 64'(held));
        step(1'b1, DECW'(1), 1'b1, 1'b0, rnd(), rnd());
        step(1'b1, DECW'(1), 1'b1, 1'b1, rnd(), rnd());
        for (int i = 0; i < 4; i++) step(1'b1, DECW'(1), 1'b1, 1'b0, rnd(), rnd());

        // Arm abort with a pending word still held by backpressure.
        for (int i = 0; i < 9; i++) step(1'b1, '0, 1'b0, 1'b1, rnd(), rnd());
        for (int i = 0; i < 2; i++) step(1'b1, '0, 1'b0, 1'b0, rnd(), rnd());
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b0, 1'b0, rnd(), rnd());
        for (int i = 0; i < 12; i++) step(1'b1, '0, (i > 1), 1'b0, rnd(), rnd());

`ifdef CHNL_SMPL_TRIG_EN
        // Single rising edge on CH_H[2] gives exactly one trigger pulse.
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            h = rnd();
            h[2] = (i >= 6);
            step(1'b1, DECW'(1), 1'b1, 1'b0, h, rnd());
            if (trig_rise[2]) pulses++;
        end
        chk("trig_pulses", 64'(pulses), 64'd1);
`endif

        // Randomised traffic.
        dcur = DECW'(1);
        acur = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) dcur = DECW'($urandom_range(0, 5));
            if ($urandom_range(0, 29) == 0) acur = ~acur;
            else if (!acur && $urandom_range(0, 3) == 0) acur = 1'b1;
            step(acur, dcur, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), rnd(), rnd());
        end

        // Asynchronous reset while a word is pending.
        for (int i = 0; i < int'(2 * SPW); i++) step(1'b1, '0, 1'b0, 1'b0, rnd(), rnd());
        step(1'b0, '0, 1'b0, 1'b0, rnd(), rnd());
        chk("pre_rst_vld", 64'(smpl_vld), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(smpl_vld), 64'd0);
        chk("arst_word", 64'(smpl_word), 64'd0);
        chk("arst_ovfl", 64'(ovfl), 64'd0);
        chk("arst_lff", 64'(CH_Lff), 64'd0);
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 40; i++) step(1'b1, DECW'($urandom_range(0, 2)), 1'b1, 1'b0, rnd(), rnd());

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
